// File: rtl/cam_mono_packer.sv
// cam_mono_packer
// Converts a stream of RGB565 camera pixels into a 1-bit-per-pixel monochrome
// image and writes it into a frame buffer as packed words.
// Each pixel is reduced to 8-bit luma, compared against a threshold, and then
// shifted into a WORD_W-bit pack register. Completed words go out on a simple
// always-accept synchronous write port. Frames whose pixel count is not
// H_ACTIVE*V_ACTIVE are flagged as erroneous.
//
// Ports:
//   PCLK_cam     camera pixel clock; this is the only clock
//   rst_n        asynchronous active-low reset
//   pixel_data   RGB565 pixel {R[15:11], G[10:5], B[4:0]}
//   pixel_valid  pixel_data is valid this cycle
//   frame_done   one-cycle end-of-frame pulse
//   thresh       luma threshold; a pixel is set when luma >= thresh
//   wr_en        frame-buffer write strobe, one cycle per word
//   wr_addr      word address of the write
//   wr_data      packed bits; bit 0 is the earliest pixel of the word
//   frame_ready  one-cycle pulse after the last word of a frame has been issued
//   frame_err    qualified by frame_ready; 1 means a wrong pixel count
module cam_mono_packer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 15
) (
  input  logic              PCLK_cam,
  input  logic              rst_n,
  input  logic [15:0]       pixel_data,
  input  logic              pixel_valid,
  input  logic              frame_done,
  input  logic [7:0]        thresh,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              frame_ready,
  output logic              frame_err
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = $clog2(TOTAL + 2);
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {WAIT_SYNC, CAPTURE, FLUSH} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        step_reg, step_next;
  logic              done_pend_reg, done_pend_next;
  logic              accept;
  logic              flush_word;
  logic              ready_pulse;
  logic              frame_clear;

  logic [CNT_W-1:0]  pix_cnt_reg;
  logic              s1_valid_reg;
  logic              s1_bit_reg;
  logic [WORD_W-1:0] pack_reg;
  logic [WORD_W-1:0] pack_next;
  logic [IDX_W-1:0]  idx_reg;
  // One bit wider than the address so that the count after the final word
  // of a full frame is representable.
  logic [ADDR_W:0]   word_cnt_reg;

  // ---------------------------------------------------------------------------
  // Luma: expand the components to 8 bits, then sum = 2R + 5G + B (max 2040).
  // ---------------------------------------------------------------------------
  logic [7:0]  r8, g8, b8;
  logic [10:0] sum;
  logic        pix_bit;

  assign r8  = {pixel_data[15:11], pixel_data[15:13]};
  assign g8  = {pixel_data[10:5],  pixel_data[10:9]};
  assign b8  = {pixel_data[4:0],   pixel_data[4:2]};
  assign sum = ({3'b000, r8} << 1) + ({3'b000, g8} << 2) + {3'b000, g8} + {3'b000, b8};

  // Y = sum[10:3]. The test Y >= thresh is the same as sum >= 8*thresh, so
  // the comparison works on the full sum and the truncation is implicit.
  assign pix_bit = (sum >= {thresh, 3'b000});

  // A pixel counts only while capturing. Pixels in WAIT_SYNC and FLUSH are
  // discarded.
  assign accept = pixel_valid && (state_reg == CAPTURE);

  // ---------------------------------------------------------------------------
  // Frame-control FSM
  // FLUSH step 0: the last pixel drains through the pack stage.
  // FLUSH step 1: emit the partial word if one is pending, otherwise end the frame.
  // FLUSH step 2: end the frame after the partial write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= WAIT_SYNC;
      step_reg      <= 2'd0;
      done_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      done_pend_reg <= done_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    done_pend_next = done_pend_reg;
    flush_word     = 1'b0;
    ready_pulse    = 1'b0;
    frame_clear    = 1'b0;
    case (state_reg)
      WAIT_SYNC: begin
        if (frame_done) begin
          state_next  = CAPTURE;
          frame_clear = 1'b1;
        end
      end
      CAPTURE: begin
        if (frame_done) begin
          state_next = FLUSH;
          step_next  = 2'd0;
        end
      end
      FLUSH: begin
        // A frame_done that arrives during a flush is remembered. It closes
        // an empty frame as soon as this flush completes.
        if (frame_done) begin
          done_pend_next = 1'b1;
        end
        case (step_reg)
          2'd0: step_next = 2'd1;
          2'd1: begin
            if (idx_reg != '0) begin
              flush_word = 1'b1;
              step_next  = 2'd2;
            end else begin
              ready_pulse = 1'b1;
            end
          end
          default: ready_pulse = 1'b1;
        endcase
        if (ready_pulse) begin
          frame_clear = 1'b1;
          step_next   = 2'd0;
          if (done_pend_reg || frame_done) begin
            state_next     = FLUSH;
            done_pend_next = 1'b0;
          end else begin
            state_next = CAPTURE;
          end
        end
      end
      default: state_next = WAIT_SYNC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel counter. It saturates one past a full frame, so an overlong frame
  // stays distinguishable from an exact one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_reg <= '0;
    end else if (frame_clear) begin
      pix_cnt_reg <= '0;
    end else if (accept && (pix_cnt_reg <= TOTAL_C)) begin
      pix_cnt_reg <= pix_cnt_reg + 1'b1;
    end
  end

  // Stage 1: thresholded bit. Pixels beyond a full frame never reach the
  // packer, so the address cannot run past the frame.
  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_bit_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= accept && (pix_cnt_reg < TOTAL_C);
      s1_bit_reg   <= pix_bit;
    end
  end

  // Place the incoming bit at the current index. All other bits are kept.
  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_pack
      assign pack_next[gi] = (idx_reg == IDX_W'(gi)) ? s1_bit_reg : pack_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 2: pack register and write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK_cam or negedge rst_n) begin
    if (!rst_n) begin
      pack_reg     <= '0;
      idx_reg      <= '0;
      word_cnt_reg <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_ready  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_ready <= 1'b0;
      frame_err   <= 1'b0;
      if (s1_valid_reg) begin
        if (idx_reg == LAST_IDX) begin
          wr_data      <= pack_next;
          wr_en        <= 1'b1;
          wr_addr      <= word_cnt_reg[ADDR_W-1:0];
          word_cnt_reg <= word_cnt_reg + 1'b1;
          pack_reg     <= '0;
          idx_reg      <= '0;
        end else begin
          pack_reg <= pack_next;
          idx_reg  <= idx_reg + 1'b1;
        end
      end else if (flush_word) begin
        // The pack register is cleared after every word, so the unused high
        // bits of a partial word are already zero.
        wr_data      <= pack_reg;
        wr_en        <= 1'b1;
        wr_addr      <= word_cnt_reg[ADDR_W-1:0];
        word_cnt_reg <= word_cnt_reg + 1'b1;
        pack_reg     <= '0;
        idx_reg      <= '0;
      end
      if (frame_clear) begin
        word_cnt_reg <= '0;
        wr_addr      <= '0;
      end
      if (ready_pulse) begin
        frame_ready <= 1'b1;
        frame_err   <= (pix_cnt_reg != TOTAL_C);
      end
    end
  end

endmodule

// File: doc/cam_mono_packer.md
# cam_mono_packer

Downstream of the camera capture stage, on the camera pixel clock. Consumes 16-bit RGB565 pixels with `pixel_valid`/`frame_done` strobes. Converts each pixel to 8-bit luma, thresholds it to 1 bit, and packs `WORD_W` bits per word into the monochrome frame buffer through a simple synchronous write port. Flags frames whose pixel count differs from `H_ACTIVE*V_ACTIVE`.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `WORD_W`, 16: pixels per frame-buffer word; power of two, 2..32.
- `ADDR_W`, 15: word address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE/WORD_W.
- `PCLK_cam` in 1: camera pixel clock; sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pixel_data` in 16: RGB565 as {R[15:11], G[10:5], B[4:0]}.
- `pixel_valid` in 1: `pixel_data` valid this cycle.
- `frame_done` in 1: one-cycle end-of-frame pulse.
- `thresh` in 8: luma threshold; quasi-static, sampled every cycle.
- `wr_en` out 1: frame-buffer write strobe, one cycle per word.
- `wr_addr` out ADDR_W: word address.
- `wr_data` out WORD_W: packed bits; bit 0 is the earliest pixel of the word.
- `frame_ready` out 1: one-cycle pulse when a frame's last word has been issued.
- `frame_err` out 1: valid only while `frame_ready` is high; 1 means pixel count ≠ H_ACTIVE*V_ACTIVE.

## Operation
- States:
  - WAIT_SYNC (reset state): discards all pixels; the first `frame_done` moves to CAPTURE with counters cleared.
  - CAPTURE: processes pixels; `frame_done` moves to FLUSH.
  - FLUSH: emits the partial word if one is pending, then pulses `frame_ready` and returns to CAPTURE with `pix_cnt`, bit index, and `wr_addr` cleared.
- Stage 1, luma, on `pixel_valid`:
  - Expand components: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - sum = 2·R8 + 5·G8 + B8, 11 bits unsigned, max 2040.
  - Y = sum[10:3].
- Stage 2, threshold and pack:
  - bit = (Y ≥ thresh).
  - Shift the bit into the pack register at the current bit index.
  - When the index reaches WORD_W−1: register the word on `wr_data`, pulse `wr_en` with the current `wr_addr`, increment `wr_addr`, clear the index.
- Frame counting:
  - `pix_cnt` counts pixels accepted in CAPTURE, saturating at H_ACTIVE*V_ACTIVE+1.
  - Pixels beyond H_ACTIVE*V_ACTIVE are dropped (no write) and make the frame erroneous.
- Short frame: `frame_done` with `pix_cnt` < H_ACTIVE*V_ACTIVE flushes the partial word, padded with zeros in the high bits, then `frame_ready` pulses with `frame_err`=1.
- `wr_addr` never exceeds H_ACTIVE*V_ACTIVE/WORD_W − 1 and wraps only through the frame-end clear.
- `pixel_valid` and `frame_done` in the same cycle: the pixel belongs to the ending frame and is packed before the flush.
- `frame_done` while in FLUSH or with the pipeline still draining: the pulse is registered and serviced after the current flush. It ends an empty frame (`frame_err`=1, no writes).

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_ready`=0, `frame_err`=0; state WAIT_SYNC; all counters 0.
- Pipeline latency from `pixel_valid` to the bit entering the pack register: 2 cycles.
- `wr_en` for a completed word asserts 2 cycles after the `pixel_valid` of that word's last pixel, for exactly one cycle.
- Frame end:
  - `frame_done` at cycle t, no pending partial word: `frame_ready` at t+3.
  - Pending partial word: its `wr_en` at t+3, `frame_ready` at t+4.
- `wr_addr`/`wr_data` are stable for the whole `wr_en` cycle.
- The write port is always-accept; there is no back-pressure.
- Accepts one pixel per cycle continuously; pixel_valid is not required to be dense.
- Reset asserted mid-frame: everything returns to reset values immediately, and the block re-enters WAIT_SYNC. The interrupted frame produces no `frame_ready`.

## Test plan
- **First frame discard:**
  - Stimulus: reset; 100 valid pixels with no prior `frame_done`.
  - Required: no `wr_en`; state stays WAIT_SYNC.
- **Luma/threshold:**
  - Stimulus: after sync, with `thresh`=128, drive 0xFFFF, 0x0000, 0xF800, 0x07E0, then 12× 0x8410.
  - Required: Y = 255, 0, 63, 159, 130 ×12.
  - Required: first `wr_data`=16'b1111_1111_1111_1001 at `wr_addr`=0.
- **Full frame:**
  - Stimulus: 307200 pixels of 0xFFFF, then `frame_done`.
  - Required: 19200 writes, addresses 0..19199, all `wr_data`=0xFFFF.
  - Required: `frame_ready` 3 cycles after `frame_done`, `frame_err`=0; the next frame starts at `wr_addr`=0.
- **Short frame:**
  - Stimulus: 20 pixels of 0xFFFF, then `frame_done`.
  - Required: writes at addr 0 (0xFFFF) and addr 1 (0x000F).
  - Required: `frame_ready` at t+4 with `frame_err`=1.
- **Overflow:**
  - Stimulus: 307216 pixels, then `frame_done`.
  - Required: exactly 19200 writes, no address ≥19200, `frame_err`=1.
- **Simultaneous and reset:**
  - Stimulus: last pixel asserted on the same cycle as `frame_done`.
  - Required: the final word is written and `frame_err`=0.
  - Stimulus: `rst_n` low mid-frame.
  - Required: outputs 0 asynchronously and no `frame_ready` for that frame.
